uart_tx_readback: RTL and testbench

- UART transmit path, the return direction of the host-to-board delay-table download.
- On a readback request it reads delay entries from one of the four delay RAMs, one entry per frame.
- Each entry is packed into an 8-byte frame and serialized on txb at a fixed baud.
- Lets the host PC verify RAM contents. Self-contained: frame builder plus bit serializer; no external UART driver.

---
 rtl/uart_tx_readback.sv | 159 +++++++++++++++
 tb/tb_uart_tx_readback.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_readback.sv
// rtl/uart_tx_readback.sv - delay-RAM readback: fetches entries and sends each as an 8-byte UART frame
module uart_tx_readback #(
    parameter int         CLKS_PER_BIT = 87,
    parameter int         RD_LAT       = 1,
    parameter logic [7:0] HDR_BYTE     = 8'h55
) (
    input  logic        I_clk_10M,
    input  logic        I_rst_n,
    input  logic [4:0]  GA,
    input  logic        I_start,
    input  logic [1:0]  I_ch_sel,
    input  logic [10:0] I_start_addr,
    input  logic [11:0] I_count,
    output logic        O_REB_RAM1,
    output logic        O_REB_RAM2,
    output logic        O_REB_RAM3,
    output logic        O_REB_RAM4,
    output logic [10:0] O_READ_ADDR,
    input  logic [23:0] I_READ_DELAY_RAM1,
    input  logic [23:0] I_READ_DELAY_RAM2,
    input  logic [23:0] I_READ_DELAY_RAM3,
    input  logic [23:0] I_READ_DELAY_RAM4,
    output logic        txb,
    output logic        O_busy,
    output logic        O_done
);
    localparam int            BW       = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]    WAIT_MAX = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, BUILD, TX_BYTE, NEXT, DONE} state_t;
    state_t state, state_nxt;

    logic [BW-1:0] baud_cnt;
    logic [3:0]    bit_idx;
    logic [2:0]    byte_idx;
    logic [1:0]    wait_cnt;
    logic [1:0]    ch;
    logic [10:0]   cur_addr;
    logic [11:0]   remaining;
    logic [23:0]   delay;
    logic [63:0]   frame;
    logic [9:0]    tx_shift;
    logic [23:0]   rd_sel;
    logic          baud_end, byte_end;
    logic [7:0]    fb1, fb2, fb3, fb4, fb5, fb6;

    assign baud_end = (baud_cnt == BAUD_MAX);
    assign byte_end = baud_end && (bit_idx == 4'd9);

    assign fb1 = {3'b000, GA};
    assign fb2 = {ch, 3'b000, cur_addr[10:8]};
    assign fb3 = cur_addr[7:0];
    assign fb4 = delay[23:16];
    assign fb5 = delay[15:8];
    assign fb6 = delay[7:0];

    always_comb begin
        rd_sel = I_READ_DELAY_RAM1;
        case (ch)
            2'd1:    rd_sel = I_READ_DELAY_RAM2;
            2'd2:    rd_sel = I_READ_DELAY_RAM3;
            2'd3:    rd_sel = I_READ_DELAY_RAM4;
            default: rd_sel = I_READ_DELAY_RAM1;
        endcase
    end

    always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
        if (!I_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (I_start) state_nxt = (I_count == 12'd0) ? DONE : RD_REQ;
            RD_REQ:  state_nxt = RD_WAIT;
            RD_WAIT: if (wait_cnt == WAIT_MAX) state_nxt = BUILD;
            BUILD:   state_nxt = TX_BYTE;
            TX_BYTE: if (byte_end && (byte_idx == 3'd7)) state_nxt = NEXT;
            NEXT:    state_nxt = (remaining == 12'd1) ? DONE : RD_REQ;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
        if (!I_rst_n) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            byte_idx  <= '0;
            wait_cnt  <= '0;
            ch        <= '0;
            cur_addr  <= '0;
            remaining <= '0;
            delay     <= '0;
            frame     <= '0;
            tx_shift  <= '1;
            O_busy    <= 1'b0;
            O_done    <= 1'b0;
        end else begin
            O_done <= 1'b0;
            case (state)
                IDLE: if (I_start) begin
                    ch        <= I_ch_sel;
                    cur_addr  <= I_start_addr;
                    remaining <= I_count;
                    O_busy    <= 1'b1;
                end
                RD_REQ: wait_cnt <= '0;
                RD_WAIT: begin
                    wait_cnt <= wait_cnt + 2'd1;
                    if (wait_cnt == WAIT_MAX) delay <= rd_sel;
                end
                BUILD: begin
                    frame    <= {fb1 ^ fb2 ^ fb3 ^ fb4 ^ fb5 ^ fb6, fb6, fb5, fb4, fb3, fb2, fb1, HDR_BYTE};
                    tx_shift <= {1'b1, HDR_BYTE, 1'b0};
                    byte_idx <= '0;
                    bit_idx  <= '0;
                    baud_cnt <= '0;
                end
                TX_BYTE: begin
                    if (!baud_end) begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end else begin
                        baud_cnt <= '0;
                        if (bit_idx == 4'd9) begin
                            // Next byte starts straight after this stop bit; frame shifts down a byte.
                            bit_idx  <= '0;
                            byte_idx <= byte_idx + 3'd1;
                            frame    <= frame >> 8;
                            tx_shift <= {1'b1, frame[15:8], 1'b0};
                        end else begin
                            bit_idx  <= bit_idx + 4'd1;
                            tx_shift <= {1'b1, tx_shift[9:1]};
                        end
                    end
                end
                NEXT: begin
                    remaining <= remaining - 12'd1;
                    if (remaining != 12'd1) cur_addr <= cur_addr + 11'd1;
                end
                DONE: begin
                    O_busy <= 1'b0;
                    O_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Driven from state so an asynchronous reset forces the line idle immediately.
    assign txb         = (state == TX_BYTE) ? tx_shift[0] : 1'b1;
    assign O_READ_ADDR = cur_addr;
    assign O_REB_RAM1  = (state == RD_REQ) && (ch == 2'd0);
    assign O_REB_RAM2  = (state == RD_REQ) && (ch == 2'd1);
    assign O_REB_RAM3  = (state == RD_REQ) && (ch == 2'd2);
    assign O_REB_RAM4  = (state == RD_REQ) && (ch == 2'd3);
endmodule

// File: tb/tb_uart_tx_readback.sv
// tb/tb_uart_tx_readback.sv - scoreboard bench for uart_tx_readback at read latencies 1 and 3
module tb_uart_tx_readback;
    localparam int CPB = 87;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic                 rst_n;
    logic [4:0]           ga;
    logic [1:0]           start;
    logic [1:0]           ch_sel;
    logic [10:0]          start_addr;
    logic [11:0]          count;
    logic [1:0][3:0]      reb;
    logic [1:0][10:0]     rd_addr;
    logic [1:0][3:0][23:0] rdata;
    logic [1:0]           txb, busy, done;

    logic [23:0] ram [4][2048];
    logic [13:0] reb_q[$];
    logic [8:0]  byte_q[$];
    int          done_cnt[2];
    int          done_cyc[2];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [1:0] enc(input logic [3:0] r);
        if (r[1]) return 2'd1;
        if (r[2]) return 2'd2;
        if (r[3]) return 2'd3;
        return 2'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int LAT = (g == 0) ? 1 : 3;

        uart_tx_readback #(.CLKS_PER_BIT(CPB), .RD_LAT(LAT), .HDR_BYTE(8'h55)) dut (
            .I_clk_10M(clk), .I_rst_n(rst_n), .GA(ga), .I_start(start[g]),
            .I_ch_sel(ch_sel), .I_start_addr(start_addr), .I_count(count),
            .O_REB_RAM1(reb[g][0]), .O_REB_RAM2(reb[g][1]),
            .O_REB_RAM3(reb[g][2]), .O_REB_RAM4(reb[g][3]),
            .O_READ_ADDR(rd_addr[g]),
            .I_READ_DELAY_RAM1(rdata[g][0]), .I_READ_DELAY_RAM2(rdata[g][1]),
            .I_READ_DELAY_RAM3(rdata[g][2]), .I_READ_DELAY_RAM4(rdata[g][3]),
            .txb(txb[g]), .O_busy(busy[g]), .O_done(done[g])
        );

        // RAM read pipeline: data is valid for exactly one cycle, LAT cycles after the enable.
        logic [3:1]        pv = '0;
        logic [3:1][1:0]   pch = '0;
        logic [3:1][23:0]  pd = '0;
        always @(posedge clk) begin
            pv  <= {pv[2:1], |reb[g]};
            pch <= {pch[2:1], enc(reb[g])};
            pd  <= {pd[2:1], ram[enc(reb[g])][rd_addr[g]]};
        end
        for (genvar c = 0; c < 4; c++) begin : rp
            assign rdata[g][c] = (pv[LAT] && pch[LAT] == 2'(c)) ? pd[LAT] : 24'h0;
        end

        initial begin
            bit         active = 0;
            int         pos = 0;
            logic       lvl = 1'b1;
            bit         stable = 1;
            logic [9:0] sh = '0;
            logic [13:0] re;
            logic [8:0]  be;
            forever begin
                @(negedge clk);
                if (rst_n !== 1'b1) begin
                    active = 0;
                end else begin
                    if (done[g] === 1'b1) begin
                        done_cnt[g]++;
                        done_cyc[g] = cyc;
                    end
                    if (reb[g] !== 4'b0) begin
                        vectors++;
                        assert (reb_q.size() != 0) else begin
                            miscompares++;
                            $error("FAIL unexpected_reb: observed %0h/%0h expected none", reb[g], rd_addr[g]);
                        end
                        if (reb_q.size() != 0) begin
                            re = reb_q.pop_front();
                            check("reb_inst", 64'(g), 64'(re[13]));
                            check("reb_onehot", reb[g], 4'b0001 << re[12:11]);
                            check("reb_addr", rd_addr[g], re[10:0]);
                        end
                    end
                    if (!active && txb[g] === 1'b0) begin
                        active = 1;
                        pos = 0;
                    end
                    if (active) begin
                        if (pos % CPB == 0) begin
                            lvl = txb[g];
                            stable = 1;
                        end else if (txb[g] !== lvl) begin
                            stable = 0;
                        end
                        if (pos % CPB == CPB - 1) begin
                            check("bit_stable", stable, 1);
                            sh = {lvl, sh[9:1]};
                            if (pos == 10 * CPB - 1) begin
                                active = 0;
                                check("stop_bit", sh[9], 1'b1);
                                vectors++;
                                assert (byte_q.size() != 0) else begin
                                    miscompares++;
                                    $error("FAIL unexpected_byte: observed %0h expected none", sh[8:1]);
                                end
                                if (byte_q.size() != 0) begin
                                    be = byte_q.pop_front();
                                    check("byte_inst", 64'(g), 64'(be[8]));
                                    check("byte_val", sh[8:1], be[7:0]);
                                end
                            end
                        end
                        pos++;
                    end
                end
            end
        end
    end

    task automatic push_entry(input int g, input logic [4:0] gv, input logic [1:0] c, input logic [10:0] a);
        logic [7:0]  b[8];
        logic [23:0] d = ram[c][a];
        logic        gb = g[0];
        b[0] = 8'h55;
        b[1] = {3'b000, gv};
        b[2] = {c, 3'b000, a[10:8]};
        b[3] = a[7:0];
        b[4] = d[23:16];
        b[5] = d[15:8];
        b[6] = d[7:0];
        b[7] = b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
        reb_q.push_back({gb, c, a});
        for (int k = 0; k < 8; k++) byte_q.push_back({gb, b[k]});
    endtask

    task automatic kick(input int g, input logic [1:0] c, input logic [10:0] a, input logic [11:0] n,
                        output int t0);
        @(posedge clk); #1;
        ch_sel = c; start_addr = a; count = n; start[g] = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start[g] = 1'b0;
    endtask

    task automatic first_bit(input int g, input int t0, input int exp_lat);
        int lat = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (txb[g] === 1'b0) begin
                lat = cyc - t0;
                break;
            end
        end
        check("first_start_bit", 64'(lat), 64'(exp_lat));
    endtask

    task automatic wait_done(input int g, input int target, input int budget);
        for (int k = 0; k < budget && done_cnt[g] < target; k++) @(negedge clk);
        check("done_count", 64'(done_cnt[g]), 64'(target));
    endtask

    initial begin
        int t0, d0;
        rst_n = 1'b0; ga = '0; start = '0; ch_sel = '0; start_addr = '0; count = '0;
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 2048; a++) ram[c][a] = 24'($urandom);

        repeat (3) @(negedge clk);
        check("rst_txb", txb, 2'b11);
        check("rst_busy", busy, 2'b00);
        check("rst_done", done, 2'b00);
        check("rst_reb", reb, 8'h00);
        check("rst_addr", rd_addr, 22'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single entry, RAM3.
        ga = 5'h0A;
        ram[2][11'h123] = 24'hABCDEF;
        push_entry(0, 5'h0A, 2'd2, 11'h123);
        kick(0, 2'd2, 11'h123, 12'd1, t0);
        first_bit(0, t0, 4);
        check("busy_in_frame", busy[0], 1'b1);
        wait_done(0, 1, 80 * CPB + 100);
        repeat (3) @(negedge clk);
        check("busy_after_done", busy[0], 1'b0);
        check("done_single_pulse", 64'(done_cnt[0]), 64'd1);

        // Three entries wrapping 2046 -> 2047 -> 0 on RAM1; GA changes after the first frame is built.
        ga = 5'h11;
        push_entry(0, 5'h11, 2'd0, 11'd2046);
        push_entry(0, 5'h12, 2'd0, 11'd2047);
        push_entry(0, 5'h12, 2'd0, 11'd0);
        kick(0, 2'd0, 11'd2046, 12'd3, t0);
        first_bit(0, t0, 4);
        ga = 5'h12;
        wait_done(0, 2, 3 * 80 * CPB + 200);

        // Zero count: done two cycles after the start cycle, no reads, no line activity.
        kick(0, 2'd1, 11'h055, 12'd0, t0);
        wait_done(0, 3, 20);
        check("zero_done_latency", 64'(done_cyc[0] - t0), 64'd2);
        repeat (5) @(negedge clk);
        check("zero_busy", busy[0], 1'b0);
        check("zero_txb", txb[0], 1'b1);

        // RD_LAT=3 instance; a second start mid-frame and a later RAM write must not disturb it.
        d0 = done_cnt[1];
        push_entry(1, 5'h12, 2'd1, 11'h400);
        kick(1, 2'd1, 11'h400, 12'd1, t0);
        first_bit(1, t0, 6);
        repeat (200) @(negedge clk);
        ram[1][11'h400] = ~ram[1][11'h400];
        kick(1, 2'd3, 11'd5, 12'd2, t0);
        check("busy_held", busy[1], 1'b1);
        wait_done(1, d0 + 1, 80 * CPB + 100);
        repeat (300) @(negedge clk);
        check("ignored_start_no_done", 64'(done_cnt[1]), 64'(d0 + 1));
        check("ignored_start_idle", busy[1], 1'b0);

        // Reset in the middle of the first byte.
        reb_q.push_back({1'b0, 2'd3, 11'h010});
        kick(0, 2'd3, 11'h010, 12'd2, t0);
        first_bit(0, t0, 4);
        repeat (200) @(negedge clk);
        @(posedge clk); #10;
        rst_n = 1'b0;
        #1;
        check("midrst_txb", txb[0], 1'b1);
        check("midrst_busy", busy[0], 1'b0);
        check("midrst_reb", reb[0], 4'h0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        d0 = done_cnt[0];
        repeat (2000) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt[0]), 64'(d0));
        check("midrst_idle_txb", txb[0], 1'b1);

        check("byte_q_drained", 64'(byte_q.size()), 64'd0);
        check("reb_q_drained", 64'(reb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
